// File: rtl/fir_mac_sched_if.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// fir_mac_sched_if: config bus, sample input and result/status bundle. Rev 1.0
// ----------------------------------------------------------------------------
interface fir_mac_sched_if #(
  parameter int DW    = 8,
  parameter int ACC_W = 19
);
  logic             cfg_we;
  logic [3:0]       cfg_addr;
  logic [7:0]       cfg_data;
  logic             pe_n;
  logic [DW-1:0]    sig_in;
  logic             busy;
  logic             out_valid;
  logic [ACC_W-1:0] out_data;
  logic             overrun;

  modport master (
    output cfg_we, cfg_addr, cfg_data, pe_n, sig_in,
    input  busy, out_valid, out_data, overrun
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, pe_n, sig_in,
    output busy, out_valid, out_data, overrun
  );
endinterface
`default_nettype wire

// File: rtl/fir_mac_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// fir_mac_sched: FIR sequencer sharing one multiplier/accumulator over all taps.
// Optional FIR_BYPASS_EN: mask bit 7 routes captured samples straight out. Rev 1.0
// ----------------------------------------------------------------------------
module fir_mac_sched #(
  parameter int TAPS  = 7,
  parameter int DW    = 8,
  parameter int ACC_W = 19
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  fir_mac_sched_if.slave bus
);
  localparam int              KW        = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [3:0]      MASK_ADDR = 4'(TAPS);
  localparam logic [KW-1:0]   LAST_K    = KW'(TAPS - 1);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_MAC = 1'b1} state_t;
  state_t state, state_nx;

  logic [DW-1:0]    coef [TAPS];
  logic [DW-1:0]    x    [TAPS];
  logic [TAPS-1:0]  mask;
  logic             pend_vld;
  logic [DW-1:0]    pend;
  logic [ACC_W-1:0] acc;
  logic [KW-1:0]    k;
  logic             byp_q;
  logic             out_valid_r;
  logic [ACC_W-1:0] out_data_r;
  logic             overrun_r;

  logic             sample;
  logic             last;
  logic             bypass;
  logic [2*DW-1:0]  prod;
  logic [ACC_W-1:0] term;
  logic             shift_live, shift_pend, load_pend, drop, do_bypass;

  assign sample = ~bus.pe_n;
  assign last   = (state == S_MAC) && (k == LAST_K);
  assign prod   = coef[k] * x[k];
  assign term   = mask[k] ? ACC_W'(prod) : '0;

`ifdef FIR_BYPASS_EN
  logic bypass_en;
  assign bypass = bypass_en;
`else
  assign bypass = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) coef[i] <= '0;
      mask <= '0;
`ifdef FIR_BYPASS_EN
      bypass_en <= 1'b0;
`endif
    end else if (bus.cfg_we) begin
      if (bus.cfg_addr < MASK_ADDR) begin
        coef[bus.cfg_addr[KW-1:0]] <= DW'(bus.cfg_data);
      end else if (bus.cfg_addr == MASK_ADDR) begin
        mask <= bus.cfg_data[TAPS-1:0];
`ifdef FIR_BYPASS_EN
        bypass_en <= bus.cfg_data[7];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    shift_live = 1'b0;
    shift_pend = 1'b0;
    load_pend  = 1'b0;
    drop       = 1'b0;
    do_bypass  = 1'b0;
    case (state)
      S_IDLE: begin
        if (sample) begin
          shift_live = 1'b1;
          if (bypass) do_bypass = 1'b1;
          else        state_nx  = S_MAC;
        end
      end
      S_MAC: begin
        if (last) begin
          // Pending is older than the live input, so it always restarts first.
          if (pend_vld) begin
            shift_pend = 1'b1;
            load_pend  = sample;
          end else if (sample) begin
            shift_live = 1'b1;
          end else begin
            state_nx = S_IDLE;
          end
        end else if (sample) begin
          if (pend_vld) drop      = 1'b1;
          else          load_pend = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) x[i] <= '0;
      pend_vld    <= 1'b0;
      pend        <= '0;
      acc         <= '0;
      k           <= '0;
      byp_q       <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      overrun_r   <= 1'b0;
    end else begin
      byp_q       <= do_bypass;
      out_valid_r <= last | byp_q;
      if (last)       out_data_r <= acc + term;
      else if (byp_q) out_data_r <= ACC_W'(x[0]);

      if (shift_live | shift_pend) begin
        x[0] <= shift_pend ? pend : bus.sig_in;
        for (int i = 1; i < TAPS; i++) x[i] <= x[i-1];
        acc <= '0;
        k   <= '0;
      end else if ((state == S_MAC) && !last) begin
        acc <= acc + term;
        k   <= k + KW'(1);
      end

      if (load_pend) begin
        pend     <= bus.sig_in;
        pend_vld <= 1'b1;
      end else if (shift_pend) begin
        pend_vld <= 1'b0;
      end

      if (bus.cfg_we && (bus.cfg_addr == MASK_ADDR)) overrun_r <= 1'b0;
      if (drop)                                      overrun_r <= 1'b1;
    end
  end

  assign bus.busy      = (state == S_MAC);
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.overrun   = overrun_r;
endmodule
`default_nettype wire

// File: tb/tb_fir_mac_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_fir_mac_sched: vector table, corner sequences and random run vs. a job model.
// ----------------------------------------------------------------------------
module tb_fir_mac_sched;
  localparam int TAPS  = 7;
  localparam int DW    = 8;
  localparam int ACC_W = 19;

  logic clk;
  logic rst_n;

  fir_mac_sched_if #(.DW(DW), .ACC_W(ACC_W)) bus ();
  fir_mac_sched #(.TAPS(TAPS), .DW(DW), .ACC_W(ACC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int               cfg;
    logic [DW-1:0]    sample;
    logic [ACC_W-1:0] exp;
  } tvec_t;

  typedef struct {
    int e;
    int v;
  } exp_t;

  int   tests;
  int   fails;
  logic [7:0] cset [TAPS];

  // Reference model: each accepted sample is a job occupying the MAC for TAPS edges.
  int   busy_until;
  bit   has_pend;
  int   pend_val;
  int   hist [TAPS];
  int   mcoef [TAPS];
  int   mmask;
  bit   mdl_ovr;
  exp_t q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = a;
    bus.cfg_data = d;
    @(negedge clk);
    bus.cfg_we   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n        = 1'b0;
    bus.cfg_we   = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_data = '0;
    bus.pe_n     = 1'b1;
    bus.sig_in   = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load_coefs();
    for (int i = 0; i < TAPS; i++) cfg_write(4'(i), cset[i]);
  endtask

  task automatic run_sample(input logic [DW-1:0] v, input logic [ACC_W-1:0] exp, input string tag);
    int early;
    early = 0;
    @(negedge clk);
    bus.pe_n   = 1'b0;
    bus.sig_in = v;
    @(negedge clk);
    bus.pe_n   = 1'b1;
    for (int i = 1; i <= TAPS; i++) begin
      @(posedge clk); #1;
      if (i < TAPS && bus.out_valid) early++;
    end
    check({tag, " early_valid"}, early, 0);
    check({tag, " valid"}, bus.out_valid, 1);
    check({tag, " data"}, bus.out_data, exp);
  endtask

  function automatic void start_job(input int v, input int t);
    int   sum;
    exp_t it;
    for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = v;
    sum = 0;
    for (int i = 0; i < TAPS; i++) if (mmask[i]) sum += mcoef[i] * hist[i];
    it.e = t + TAPS;
    it.v = sum % (1 << ACC_W);
    q.push_back(it);
    busy_until = t + TAPS;
  endfunction

  initial begin
    tvec_t tv [12];
    int    prev_cfg;
    int    npulse, p1_at, p2_at, p1_val, p2_val, vcnt;
    bit    pe;
    int    v;
    bit    exp_valid;

    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
    bus.pe_n = 1'b1; bus.sig_in = '0;

    tv[0]  = '{0, 8'd65,  19'd65};
    tv[1]  = '{0, 8'd66,  19'd196};
    tv[2]  = '{0, 8'd67,  19'd394};
    tv[3]  = '{0, 8'd68,  19'd400};
    tv[4]  = '{0, 8'd69,  19'd406};
    tv[5]  = '{1, 8'd255, 19'd255};
    tv[6]  = '{1, 8'd255, 19'd765};
    tv[7]  = '{1, 8'd255, 19'd1530};
    tv[8]  = '{1, 8'd255, 19'd1530};
    tv[9]  = '{1, 8'd255, 19'd1785};
    tv[10] = '{1, 8'd255, 19'd2295};
    tv[11] = '{1, 8'd255, 19'd3060};

    do_reset();
    @(posedge clk); #1;
    check("reset busy", bus.busy, 0);
    check("reset out_valid", bus.out_valid, 0);
    check("reset out_data", bus.out_data, 0);
    check("reset overrun", bus.overrun, 0);

    // Vector table: coefs 1,2,3,0,1,2,3 with mask 0x0F then 0x7F.
    prev_cfg = -1;
    for (int i = 0; i < 12; i++) begin
      if (tv[i].cfg != prev_cfg) begin
        do_reset();
        cset = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd2, 8'd3};
        load_coefs();
        cfg_write(4'd7, (tv[i].cfg == 0) ? 8'h0F : 8'h7F);
        prev_cfg = tv[i].cfg;
      end
      run_sample(tv[i].sample, tv[i].exp, $sformatf("vec%0d", i));
      repeat (2) @(negedge clk);
    end

    // Three back-to-back samples: one pended, one dropped.
    do_reset();
    cset = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    load_coefs();
    cfg_write(4'd7, 8'h01);
    npulse = 0; p1_at = -1; p2_at = -1; p1_val = -1; p2_val = -1;
    @(negedge clk);
    bus.pe_n = 1'b0; bus.sig_in = 8'd1;
    for (int i = 0; i <= 20; i++) begin
      @(posedge clk); #1;
      if (i == 1) check("burst busy", bus.busy, 1);
      if (bus.out_valid) begin
        npulse++;
        if (npulse == 1) begin p1_at = i; p1_val = int'(bus.out_data); end
        if (npulse == 2) begin p2_at = i; p2_val = int'(bus.out_data); end
      end
      @(negedge clk);
      if (i == 0)      bus.sig_in = 8'd2;
      else if (i == 1) bus.sig_in = 8'd3;
      else             bus.pe_n   = 1'b1;
    end
    check("burst pulses", npulse, 2);
    check("burst p1 edge", p1_at, 7);
    check("burst p1 data", p1_val, 1);
    check("burst p2 edge", p2_at, 14);
    check("burst p2 data", p2_val, 2);
    check("burst overrun", bus.overrun, 1);
    cfg_write(4'd7, 8'h01);
    #1;
    check("overrun cleared", bus.overrun, 0);

    // Mid-MAC coefficient write and ignored address 9.
    do_reset();
    cset = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1};
    load_coefs();
    cfg_write(4'd7, 8'h42);
    run_sample(8'd9, 19'd0, "fill0");
    for (int i = 1; i < 6; i++) run_sample(8'd1, 19'd0, $sformatf("fill%0d", i));
    @(negedge clk);
    bus.pe_n = 1'b0; bus.sig_in = 8'd1;
    @(negedge clk);
    bus.pe_n = 1'b1;
    bus.cfg_we = 1'b1; bus.cfg_addr = 4'd6; bus.cfg_data = 8'd5;
    @(negedge clk);
    bus.cfg_addr = 4'd9; bus.cfg_data = 8'hFF;
    @(negedge clk);
    bus.cfg_we = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("midwrite valid", bus.out_valid, 1);
    check("midwrite data", bus.out_data, 45);
    run_sample(8'd0, 19'd5, "addr9 ignored");

    // Reset while a burst is in flight.
    @(negedge clk);
    bus.pe_n = 1'b0; bus.sig_in = 8'd7;
    @(negedge clk); bus.sig_in = 8'd8;
    @(negedge clk); bus.sig_in = 8'd9;
    @(negedge clk); bus.pe_n = 1'b1;
    @(posedge clk); #1;
    check("pre-abort busy", bus.busy, 1);
    check("pre-abort overrun", bus.overrun, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort busy", bus.busy, 0);
    check("abort out_valid", bus.out_valid, 0);
    check("abort out_data", bus.out_data, 0);
    check("abort overrun", bus.overrun, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) vcnt++;
    end
    check("abort no valid", vcnt, 0);
    cfg_write(4'd7, 8'h7F);
    run_sample(8'd10, 19'd0, "post-reset coefs");

`ifdef FIR_BYPASS_EN
    do_reset();
    cfg_write(4'd7, 8'h80);
    npulse = 0; p1_at = -1; p1_val = -1; vcnt = 0;
    @(negedge clk);
    bus.pe_n = 1'b0; bus.sig_in = 8'd42;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.busy) vcnt++;
      if (bus.out_valid) begin
        npulse++;
        p1_at  = i;
        p1_val = int'(bus.out_data);
      end
      @(negedge clk);
      bus.pe_n = 1'b1;
    end
    check("bypass pulses", npulse, 1);
    check("bypass edge", p1_at, 1);
    check("bypass data", p1_val, 42);
    check("bypass busy", vcnt, 0);
`endif

    // Random traffic against the job model.
    do_reset();
    for (int i = 0; i < TAPS; i++) begin
      cset[i]  = 8'($urandom_range(0, 255));
      mcoef[i] = int'(cset[i]);
      hist[i]  = 0;
    end
    load_coefs();
    mmask = int'($urandom_range(0, 127));
    cfg_write(4'd7, 8'(mmask));
    busy_until = -100;
    has_pend   = 1'b0;
    pend_val   = 0;
    mdl_ovr    = 1'b0;
    q.delete();
    for (int t = 0; t < 800; t++) begin
      @(negedge clk);
      pe = (t < 780) && ($urandom_range(0, 99) < 35);
      v  = int'($urandom_range(0, 255));
      bus.pe_n   = ~pe;
      bus.sig_in = 8'(v);
      if (has_pend && t == busy_until) begin
        has_pend = 1'b0;
        start_job(pend_val, t);
      end
      if (pe) begin
        if (t >= busy_until) start_job(v, t);
        else if (!has_pend) begin has_pend = 1'b1; pend_val = v; end
        else mdl_ovr = 1'b1;
      end
      @(posedge clk); #1;
      exp_valid = (q.size() > 0) && (q[0].e == t);
      check($sformatf("rand valid t=%0d", t), bus.out_valid, exp_valid);
      check($sformatf("rand busy t=%0d", t), bus.busy, (t < busy_until));
      if (exp_valid) begin
        check($sformatf("rand data t=%0d", t), bus.out_data, q[0].v);
        void'(q.pop_front());
      end
    end
    check("rand overrun", bus.overrun, mdl_ovr);
    check("rand outstanding", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
